data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Shares the MEM-stage data memory between the pipeline and the debug unit. The pipeline owns the memory port while running. When the pipeline is halted, the debug unit can request a full memory dump. The block then sequences word-by-word reads across the whole memory and streams each word to the debug unit over a valid/ready handshake. It sits between the MEM stage's memory-control outputs and the `data_memory` instance.

## Interface
- `NB_ADDR`, 32, memory address width
- `NB_DATA`, 32, memory word width
- `MEM_DEPTH`, 32, number of words dumped (≥2)
- `ADDR_STRIDE`, 1, address increment per dumped word (4 for byte addressing)

Ports:
- `i_clock`  in  1  single clock; all logic on rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_pipe_halted`  in  1  pipeline halted (HALT reached / debug stop)
- `i_pipe_mem_read`, `i_pipe_mem_write`  in  1  MEM-stage read/write flags
- `i_pipe_addr`  in  NB_ADDR  MEM-stage address (ALU result)
- `i_pipe_wdata`  in  NB_DATA  MEM-stage store data
- `o_pipe_rdata`  out  NB_DATA  read data to MEM stage
- `i_dbg_dump_start`  in  1  one-cycle dump request
- `o_dbg_word`  out  NB_DATA  dumped word
- `o_dbg_word_valid`  out  1  dumped word available
- `i_dbg_word_ready`  in  1  debug unit accepts word
- `o_dbg_busy`  out  1  dump in progress
- `o_dbg_done`  out  1  one-cycle pulse: all MEM_DEPTH words delivered
- `o_dbg_abort`  out  1  one-cycle pulse: dump aborted
- `o_mem_read`, `o_mem_write`  out  1  to data memory
- `o_mem_addr`  out  NB_ADDR  to data memory
- `o_mem_wdata`  out  NB_DATA  to data memory
- `i_mem_rdata`  in  NB_DATA  from data memory (1-cycle synchronous read)

## Operation
- FSM states: IDLE, READ, WAIT, SEND, DONE.
- **IDLE:**
  - Memory port = pipeline signals, passed through combinationally.
  - `i_dbg_dump_start` with `i_pipe_halted`=1 → READ, with index=0.
  - A start request while not halted is ignored.
- **READ:** `o_mem_read`=1, `o_mem_write`=0, `o_mem_addr`=index*ADDR_STRIDE (zero-extended, truncated to NB_ADDR). Next state is WAIT.
- **WAIT:** capture `i_mem_rdata` into the word register. Next state is SEND.
- **SEND:**
  - `o_dbg_word_valid` = (state==SEND) & `i_pipe_halted`.
  - On valid&ready: if index==MEM_DEPTH-1 → DONE; otherwise index+1 → READ.
  - `o_dbg_word` stays stable while valid && !ready.
- **DONE:** `o_dbg_done`=1 for one cycle, then IDLE.
- **Port ownership while busy:** in READ/WAIT/SEND/DONE, pipeline requests are gated. `o_mem_write`=0 always; `o_mem_read` is driven only by READ.
- `o_pipe_rdata` = `i_mem_rdata` in every state.
- `o_dbg_busy` = (state != IDLE).
- **Abort:** `i_pipe_halted`=0 sampled in any non-IDLE state (DONE excepted) → next state is IDLE, with `o_dbg_abort`=1 for one cycle. Abort has priority over the handshake; valid is gated, so no word is transferred in that cycle.
- A start request while busy is ignored.
- Ready without valid is ignored.
- Index width is clog2(MEM_DEPTH); no wrap is possible, because DONE is taken at MEM_DEPTH-1.

## Timing
- **Reset values:** state=IDLE, index=0, word register=0. `o_dbg_word_valid`, `o_dbg_busy`, `o_dbg_done` and `o_dbg_abort` are all 0. Memory outputs follow the pipeline inputs (combinational).
- Reset mid-dump → IDLE on the next edge; no done or abort pulse.
- **Dump timing:**
  - Start accepted at edge t.
  - READ during cycle t+1.
  - WAIT during t+2.
  - First valid at t+3.
  - Per word: 3 cycles plus handshake wait.
  - Total with ready held high: 3*MEM_DEPTH+1 cycles from start to the done pulse.
- Pipeline path: zero added latency; purely combinational in IDLE.

## Configuration
- **`MEM_ARB_DBG_WRITE_EN` defined:** adds ports `i_dbg_wr` (1), `i_dbg_wr_addr` (NB_ADDR) and `i_dbg_wr_data` (NB_DATA).
  - In IDLE with halted=1, `i_dbg_wr`=1 drives `o_mem_write`=1 with the debug address and data in that cycle, overriding the pipeline.
  - If `i_dbg_wr` and `i_dbg_dump_start` arrive together, the write is performed and the start is ignored.
  - `i_dbg_wr` is ignored when not halted or when busy.
- **Undefined:** those ports do not exist; the debug unit has read-only access.

## Structure
- Package `mem_arb_pkg`: FSM state encoding localparams (3 bits) and the clog2 helper.
- One sub-module, `mem_dump_seq`, contains the FSM, index counter and word register, and outputs the debug-side memory request.
- The top level holds only the ownership mux.

## Test plan
- **Pipeline passthrough:** halted=0, pipe write addr 0x8, data 0xDEADBEEF → `o_mem_write`=1, `o_mem_addr`=0x8 in the same cycle; a later read at 0x8 returns 0xDEADBEEF on `o_pipe_rdata` next cycle.
- **Full dump:** MEM_DEPTH=4, memory preloaded {0x11,0x22,0x33,0x44}, halted=1, ready=1 → words 0x11..0x44 in order, first valid 3 cycles after start, `o_dbg_done` 13 cycles after start.
- **Backpressure:** ready=0 for 5 cycles on word 1 → `o_dbg_word` is held at 0x22 with valid high; no read issued until accepted.
- **Abort:** halted drops during SEND of word 2 → valid=0 that cycle, `o_dbg_abort` pulse, IDLE next cycle, no done; a new start then restarts from index 0.
- **Ignored start:** start with halted=0 → busy stays 0 and the memory port is unchanged. Start while busy → the dump continues unaffected.
- **`MEM_ARB_DBG_WRITE_EN`:** halted, `i_dbg_wr` addr 0x3 data 0x5A5A5A5A → `o_mem_write`=1 that cycle; a subsequent dump shows 0x5A5A5A5A at index 3.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: dump FSM state encoding and an index-width helper.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StRead = 3'd1,
        StWait = 3'd2,
        StSend = 3'd3,
        StDone = 3'd4
    } dump_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Debug-unit handshake plus data-memory bus seen by the arbiter (names from the arbiter's side).
// Optional debug write port present when MEM_ARB_DBG_WRITE_EN is defined.
interface data_mem_arbiter_if #(
    parameter int unsigned NB_ADDR = 32,
    parameter int unsigned NB_DATA = 32
);
    logic               i_dbg_dump_start;
    logic [NB_DATA-1:0] o_dbg_word;
    logic               o_dbg_word_valid;
    logic               i_dbg_word_ready;
    logic               o_dbg_busy;
    logic               o_dbg_done;
    logic               o_dbg_abort;
    logic               o_mem_read;
    logic               o_mem_write;
    logic [NB_ADDR-1:0] o_mem_addr;
    logic [NB_DATA-1:0] o_mem_wdata;
    logic [NB_DATA-1:0] i_mem_rdata;
`ifdef MEM_ARB_DBG_WRITE_EN
    logic               i_dbg_wr;
    logic [NB_ADDR-1:0] i_dbg_wr_addr;
    logic [NB_DATA-1:0] i_dbg_wr_data;
`endif

    modport slave (
        input  i_dbg_dump_start, i_dbg_word_ready, i_mem_rdata,
`ifdef MEM_ARB_DBG_WRITE_EN
        input  i_dbg_wr, i_dbg_wr_addr, i_dbg_wr_data,
`endif
        output o_dbg_word, o_dbg_word_valid, o_dbg_busy, o_dbg_done, o_dbg_abort,
        output o_mem_read, o_mem_write, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_dbg_dump_start, i_dbg_word_ready, i_mem_rdata,
`ifdef MEM_ARB_DBG_WRITE_EN
        output i_dbg_wr, i_dbg_wr_addr, i_dbg_wr_data,
`endif
        input  o_dbg_word, o_dbg_word_valid, o_dbg_busy, o_dbg_done, o_dbg_abort,
        input  o_mem_read, o_mem_write, o_mem_addr, o_mem_wdata
    );

endinterface

// File: rtl/mem_dump_seq.sv
// Memory-dump sequencer: walks every word, reads it, and hands it to the debug unit.
module mem_dump_seq
    import mem_arb_pkg::*;
#(
    parameter int unsigned NB_ADDR     = 32,
    parameter int unsigned NB_DATA     = 32,
    parameter int unsigned MEM_DEPTH   = 32,
    parameter int unsigned ADDR_STRIDE = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               halted_i,
    input  logic               start_i,
    input  logic               word_ready_i,
    input  logic [NB_DATA-1:0] mem_rdata_i,
    output logic               busy_o,
    output logic               mem_read_o,
    output logic [NB_ADDR-1:0] mem_addr_o,
    output logic [NB_DATA-1:0] word_o,
    output logic               word_valid_o,
    output logic               done_o,
    output logic               abort_o
);
    localparam int unsigned IdxW = clog2(MEM_DEPTH);

    dump_state_e        state_q;
    logic [IdxW-1:0]    idx_q;
    logic [NB_DATA-1:0] word_q;
    logic               abort_q;
    logic               last_word;

    assign last_word = (idx_q == IdxW'(MEM_DEPTH - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            word_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i && halted_i) begin
                        state_q <= StRead;
                        idx_q   <= '0;
                    end
                end
                StRead: begin
                    if (!halted_i) begin
                        state_q <= StIdle;
                        abort_q <= 1'b1;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (!halted_i) begin
                        state_q <= StIdle;
                        abort_q <= 1'b1;
                    end else begin
                        word_q  <= mem_rdata_i;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    // Abort wins over a simultaneous ready; valid is already gated by halted.
                    if (!halted_i) begin
                        state_q <= StIdle;
                        abort_q <= 1'b1;
                    end else if (word_ready_i) begin
                        if (last_word) begin
                            state_q <= StDone;
                        end else begin
                            idx_q   <= idx_q + IdxW'(1);
                            state_q <= StRead;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o       = (state_q != StIdle);
    assign mem_read_o   = (state_q == StRead);
    assign mem_addr_o   = NB_ADDR'(idx_q) * NB_ADDR'(ADDR_STRIDE);
    assign word_o       = word_q;
    assign word_valid_o = (state_q == StSend) && halted_i;
    assign done_o       = (state_q == StDone);
    assign abort_o      = abort_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Data-memory ownership mux: pipeline in IDLE, dump sequencer while busy.
// MEM_ARB_DBG_WRITE_EN adds a debug write path that overrides the pipeline while halted and idle.
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NB_ADDR     = 32,
    parameter int unsigned NB_DATA     = 32,
    parameter int unsigned MEM_DEPTH   = 32,
    parameter int unsigned ADDR_STRIDE = 1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_pipe_halted,
    input  logic                i_pipe_mem_read,
    input  logic                i_pipe_mem_write,
    input  logic [NB_ADDR-1:0]  i_pipe_addr,
    input  logic [NB_DATA-1:0]  i_pipe_wdata,
    output logic [NB_DATA-1:0]  o_pipe_rdata,
    data_mem_arbiter_if.slave   bus
);
    logic               seq_busy;
    logic               seq_read;
    logic [NB_ADDR-1:0] seq_addr;
    logic [NB_DATA-1:0] seq_word;
    logic               seq_valid;
    logic               seq_done;
    logic               seq_abort;
    logic               start_req;

`ifdef MEM_ARB_DBG_WRITE_EN
    // A debug write in the same cycle as a dump request takes precedence.
    assign start_req = bus.i_dbg_dump_start && !bus.i_dbg_wr;
`else
    assign start_req = bus.i_dbg_dump_start;
`endif

    mem_dump_seq #(
        .NB_ADDR     (NB_ADDR),
        .NB_DATA     (NB_DATA),
        .MEM_DEPTH   (MEM_DEPTH),
        .ADDR_STRIDE (ADDR_STRIDE)
    ) u_seq (
        .clk_i        (i_clock),
        .rst_i        (i_reset),
        .halted_i     (i_pipe_halted),
        .start_i      (start_req),
        .word_ready_i (bus.i_dbg_word_ready),
        .mem_rdata_i  (bus.i_mem_rdata),
        .busy_o       (seq_busy),
        .mem_read_o   (seq_read),
        .mem_addr_o   (seq_addr),
        .word_o       (seq_word),
        .word_valid_o (seq_valid),
        .done_o       (seq_done),
        .abort_o      (seq_abort)
    );

    always_comb begin
        bus.o_mem_read  = i_pipe_mem_read;
        bus.o_mem_write = i_pipe_mem_write;
        bus.o_mem_addr  = i_pipe_addr;
        bus.o_mem_wdata = i_pipe_wdata;
        if (seq_busy) begin
            bus.o_mem_read  = seq_read;
            bus.o_mem_write = 1'b0;
            bus.o_mem_addr  = seq_addr;
            bus.o_mem_wdata = '0;
        end
`ifdef MEM_ARB_DBG_WRITE_EN
        else if (i_pipe_halted && bus.i_dbg_wr) begin
            bus.o_mem_read  = 1'b0;
            bus.o_mem_write = 1'b1;
            bus.o_mem_addr  = bus.i_dbg_wr_addr;
            bus.o_mem_wdata = bus.i_dbg_wr_data;
        end
`endif
    end

    assign o_pipe_rdata         = bus.i_mem_rdata;
    assign bus.o_dbg_word       = seq_word;
    assign bus.o_dbg_word_valid = seq_valid;
    assign bus.o_dbg_busy       = seq_busy;
    assign bus.o_dbg_done       = seq_done;
    assign bus.o_dbg_abort      = seq_abort;

endmodule
